// File: rtl/tdm_pkg.sv
// Shared types and sizing helpers for the TDM demultiplexer slice.
// Slot-index width and frame length are both derived from the select width K.
package tdm_pkg;

    localparam int DEFAULT_K = 4;

    typedef enum logic [0:0] {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    // Slot index type for the default configuration; parameterised users size by K.
    typedef logic [DEFAULT_K-1:0] slot_t;

    function automatic int frame_slots(input int k);
        return 1 << k;
    endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Modulo-2**K slot counter: load1 restarts a frame at slot 1, inc advances and wraps.
// load1 has priority so a resync bit can never be double-counted.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int K = DEFAULT_K
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         load1,
    output logic [K-1:0] count,
    output logic         last
);

    localparam logic [K-1:0] ONE = K'(1);
    localparam logic [K-1:0] TOP = K'(frame_slots(K) - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load1) begin
            count <= ONE;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    assign last = (count == TOP);

endmodule

// File: rtl/tdm_demux.sv
// Receiving end of a 2**K:1 TDM line: aligns on frame_start, collects one bit per
// valid cycle and emits each completed frame as an N-bit word with a one-cycle strobe.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int K = DEFAULT_K
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            din,
    input  logic            din_valid,
    input  logic            frame_start,
    output logic [2**K-1:0] dout,
    output logic            dout_valid,
    output logic [K-1:0]    slot,
    output logic            locked,
    output logic            sync_err
);

    localparam int N = frame_slots(K);

    state_t       state;
    logic [N-2:0] shadow;
    logic [K-1:0] count;
    logic         last;
    logic         accept;
    logic         start;
    logic         resync;
    logic         inc;
    logic         load1;

    // frame_start only matters on valid cycles; in RECV it is an error unless at slot 0,
    // including on the completion slot, where it suppresses the frame.
    assign accept = din_valid && (state == RECV);
    assign start  = din_valid && frame_start && (state == HUNT);
    assign resync = accept && frame_start && (count != '0);
    assign inc    = accept && !resync;
    assign load1  = start || resync;

    tdm_slot_counter #(
        .K(K)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (inc),
        .load1(load1),
        .count(count),
        .last (last)
    );

    assign slot = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            locked     <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
            shadow     <= '0;
        end else begin
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;

            if (state == HUNT) begin
                if (start) begin
                    state  <= RECV;
                    locked <= 1'b1;
                end
            end else begin
                state  <= RECV;
                locked <= 1'b1;
            end

            if (load1) begin
                shadow[0] <= din;
            end else if (inc && !last) begin
                for (int i = 0; i < N - 1; i++) begin
                    if (count == K'(i)) begin
                        shadow[i] <= din;
                    end
                end
            end

            if (resync) begin
                sync_err <= 1'b1;
            end

            // The last slot bit goes straight to dout; it never needs a shadow cell.
            if (inc && last) begin
                dout       <= {din, shadow};
                dout_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frame table, hand-written corner sequences,
// and randomized traffic compared against a queue-based frame model.
module tb_tdm_demux;

    localparam int K = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         din, dv, fs;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic [K-1:0] slot;
    logic         locked;
    logic         sync_err;

    logic         din1, dv1, fs1;
    logic [1:0]   dout1;
    logic         dvld1;
    logic [0:0]   slot1;
    logic         locked1;
    logic         serr1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int           dv_cyc[$];
    logic [N-1:0] dv_val[$];

    bit           m_bits[$];
    bit           m_locked;
    logic [N-1:0] m_dout;
    bit           m_dv;
    bit           m_serr;

    always #5 clk = ~clk;

    tdm_demux #(.K(K)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (dv),
        .frame_start(fs),
        .dout       (dout),
        .dout_valid (dout_valid),
        .slot       (slot),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    tdm_demux #(.K(1)) u_k1 (
        .clk        (clk),
        .rst        (rst),
        .din        (din1),
        .din_valid  (dv1),
        .frame_start(fs1),
        .dout       (dout1),
        .dout_valid (dvld1),
        .slot       (slot1),
        .locked     (locked1),
        .sync_err   (serr1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame-level model: a frame is the list of bits accepted since alignment.
    task automatic model_reset();
        m_bits.delete();
        m_locked = 1'b0;
        m_dout   = '0;
        m_dv     = 1'b0;
        m_serr   = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit f);
        m_dv   = 1'b0;
        m_serr = 1'b0;
        if (!v) return;
        if (!m_locked) begin
            if (f) begin
                m_locked = 1'b1;
                m_bits   = {d};
            end
            return;
        end
        if (f && m_bits.size() != 0) begin
            m_serr = 1'b1;
            m_bits = {d};
            return;
        end
        m_bits.push_back(d);
        if (m_bits.size() == N) begin
            for (int i = 0; i < N; i++) m_dout[i] = m_bits[i];
            m_dv = 1'b1;
            m_bits.delete();
        end
    endtask

    task automatic cmp(input string tag);
        check({tag, ".dout"},     32'(dout),       32'(m_dout));
        check({tag, ".dvalid"},   32'(dout_valid), 32'(m_dv));
        check({tag, ".slot"},     32'(slot),       32'(m_bits.size()));
        check({tag, ".locked"},   32'(locked),     32'(m_locked));
        check({tag, ".sync_err"}, 32'(sync_err),   32'(m_serr));
    endtask

    task automatic step(input string tag, input bit d, input bit v, input bit f);
        din = d;
        dv  = v;
        fs  = f;
        @(posedge clk);
        #1;
        cyc++;
        model_step(d, v, f);
        if (dout_valid) begin
            dv_cyc.push_back(cyc);
            dv_val.push_back(dout);
        end
        cmp(tag);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        din  = 1'b0;
        dv   = 1'b0;
        fs   = 1'b0;
        din1 = 1'b0;
        dv1  = 1'b0;
        fs1  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        dv_cyc.delete();
        dv_val.delete();
        rst = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [N-1:0] w, input bit fs_first,
                              input int ga, input int gb, input int gl);
        for (int i = 0; i < N; i++) begin
            step(tag, w[i], 1'b1, fs_first && i == 0);
            if (i == ga || i == gb) begin
                for (int g = 0; g < gl; g++) step(tag, 1'b0, 1'b0, 1'b0);
            end
        end
    endtask

    typedef struct {
        string        name;
        logic [N-1:0] word;
        int           ga;
        int           gb;
        int           gl;
        int           exp_lat;
    } vec_t;

    initial begin
        vec_t tbl[3];
        int   start_cyc;
        int   lat;

        tbl[0] = '{"basic",  16'hA5C3, -1, -1, 0, 16};
        tbl[1] = '{"gapped", 16'hA5C3,  4, 11, 3, 22};
        tbl[2] = '{"edges",  16'h8001, -1, -1, 0, 16};

        // Reset state, observed while rst is held.
        rst = 1'b1;
        din = 1'b0; dv = 1'b0; fs = 1'b0;
        din1 = 1'b0; dv1 = 1'b0; fs1 = 1'b0;
        #2;
        check("rst.dout",   32'(dout),       32'h0);
        check("rst.dvalid", 32'(dout_valid), 32'h0);
        check("rst.slot",   32'(slot),       32'h0);
        check("rst.locked", 32'(locked),     32'h0);
        check("rst.serr",   32'(sync_err),   32'h0);
        do_reset();

        // Hunt: valid bits without frame_start are discarded.
        for (int i = 0; i < 20; i++) begin
            step("hunt", 1'($urandom), 1'b1, 1'b0);
            check("hunt.locked", 32'(locked),     32'h0);
            check("hunt.dvalid", 32'(dout_valid), 32'h0);
            check("hunt.slot",   32'(slot),       32'h0);
        end
        step("hunt_fs_novalid", 1'b1, 1'b0, 1'b1);
        check("hunt_fs_novalid.locked", 32'(locked), 32'h0);

        // Directed frame table.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            start_cyc = cyc;
            send_frame(tbl[t].name, tbl[t].word, 1'b1, tbl[t].ga, tbl[t].gb, tbl[t].gl);
            lat = (dv_cyc.size() > 0) ? dv_cyc[0] - start_cyc : -1;
            check({tbl[t].name, ".pulses"},  32'(dv_cyc.size()), 32'd1);
            check({tbl[t].name, ".word"},    (dv_val.size() > 0) ? 32'(dv_val[0]) : 32'hDEAD, 32'(tbl[t].word));
            check({tbl[t].name, ".latency"}, 32'(lat), 32'(tbl[t].exp_lat));
            check({tbl[t].name, ".slot"},    32'(slot), 32'h0);
            check({tbl[t].name, ".locked"},  32'(locked), 32'h1);
            for (int i = 0; i < 4; i++) step("hold", 1'b0, 1'b0, 1'b0);
            check({tbl[t].name, ".hold"},    32'(dout), 32'(tbl[t].word));
        end

        // Back-to-back frames, frame_start only on the first.
        do_reset();
        send_frame("b2b", 16'h1234, 1'b1, -1, -1, 0);
        send_frame("b2b", 16'hFFFF, 1'b0, -1, -1, 0);
        check("b2b.pulses", 32'(dv_cyc.size()), 32'd2);
        if (dv_cyc.size() == 2) begin
            check("b2b.first",   32'(dv_val[0]), 32'h1234);
            check("b2b.second",  32'(dv_val[1]), 32'hFFFF);
            check("b2b.spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd16);
        end

        // frame_start without valid in RECV is ignored.
        do_reset();
        for (int i = 0; i < 5; i++) step("ign", 1'b1, 1'b1, i == 0);
        step("ign", 1'b1, 1'b0, 1'b1);
        check("ign.slot", 32'(slot),     32'd5);
        check("ign.serr", 32'(sync_err), 32'h0);

        // Resync at slot 9, then a fresh 16'h0F0F frame.
        do_reset();
        for (int i = 0; i < 9; i++) step("resync", 1'b1, 1'b1, i == 0);
        check("resync.pre_slot", 32'(slot), 32'd9);
        step("resync", 1'b1, 1'b1, 1'b1);
        check("resync.serr",   32'(sync_err),   32'h1);
        check("resync.dvalid", 32'(dout_valid), 32'h0);
        check("resync.slot",   32'(slot),       32'd1);
        check("resync.locked", 32'(locked),     32'h1);
        for (int i = 1; i < N; i++) begin
            step("resync", 1'(16'h0F0F >> i), 1'b1, 1'b0);
            if (i == 1) check("resync.serr_pulse", 32'(sync_err), 32'h0);
        end
        check("resync.pulses", 32'(dv_cyc.size()), 32'd1);
        check("resync.word", (dv_val.size() > 0) ? 32'(dv_val[0]) : 32'hDEAD, 32'h0F0F);

        // frame_start on the completion slot is a resync, not a completion.
        do_reset();
        for (int i = 0; i < N - 1; i++) step("lastfs", 1'b0, 1'b1, i == 0);
        check("lastfs.pre_slot", 32'(slot), 32'd15);
        step("lastfs", 1'b1, 1'b1, 1'b1);
        check("lastfs.serr",   32'(sync_err),   32'h1);
        check("lastfs.dvalid", 32'(dout_valid), 32'h0);
        check("lastfs.slot",   32'(slot),       32'd1);
        check("lastfs.pulses", 32'(dv_cyc.size()), 32'd0);

        // Asynchronous reset mid-frame after a completed frame.
        do_reset();
        send_frame("midrst", 16'hBEEF, 1'b1, -1, -1, 0);
        for (int i = 0; i < 7; i++) step("midrst", 1'b1, 1'b1, 1'b0);
        check("midrst.pre_slot", 32'(slot), 32'd7);
        check("midrst.pre_dout", 32'(dout), 32'hBEEF);
        #2;
        rst = 1'b1;
        #1;
        check("midrst.dout",   32'(dout),     32'h0);
        check("midrst.slot",   32'(slot),     32'h0);
        check("midrst.locked", 32'(locked),   32'h0);
        check("midrst.serr",   32'(sync_err), 32'h0);
        do_reset();
        for (int i = 0; i < 5; i++) step("midrst_hunt", 1'b1, 1'b1, 1'b0);
        check("midrst.hunt", 32'(locked), 32'h0);

        // K=1: two-slot frame.
        din1 = 1'b1; dv1 = 1'b0; fs1 = 1'b1;
        @(posedge clk); #1;
        check("k1.fs_novalid", 32'(locked1), 32'h0);
        din1 = 1'b1; dv1 = 1'b1; fs1 = 1'b1;
        @(posedge clk); #1;
        check("k1.slot1",  32'(slot1),   32'h1);
        check("k1.locked", 32'(locked1), 32'h1);
        check("k1.dv0",    32'(dvld1),   32'h0);
        din1 = 1'b0; dv1 = 1'b1; fs1 = 1'b0;
        @(posedge clk); #1;
        check("k1.dout",  32'(dout1), 32'h1);
        check("k1.dv",    32'(dvld1), 32'h1);
        check("k1.slot0", 32'(slot1), 32'h0);
        check("k1.serr",  32'(serr1), 32'h0);
        din1 = 1'b1; dv1 = 1'b1; fs1 = 1'b0;
        @(posedge clk); #1;
        din1 = 1'b1; dv1 = 1'b1; fs1 = 1'b1;
        @(posedge clk); #1;
        check("k1.resync_serr", 32'(serr1), 32'h1);
        check("k1.resync_dv",   32'(dvld1), 32'h0);
        check("k1.hold",        32'(dout1), 32'h1);
        dv1 = 1'b0; fs1 = 1'b0;

        // Randomized traffic against the frame model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step("rnd", 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
